// File: rtl/oh_simaligner_pkg.sv
// Shared helpers for the simulation aligner stage.
package oh_simaligner_pkg;

   // Bits needed to hold 0..max_val; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      if (max_val == 0) return 1;
      return 32'($clog2(max_val + 1));
   endfunction

endpackage

// File: rtl/oh_simaligner_fifo.sv
// Expected-value queue: circular buffer with one extra pointer bit to tell full from empty.
module oh_simaligner_fifo
   import oh_simaligner_pkg::*;
#(
   parameter int unsigned DW    = 32,
   parameter int unsigned DEPTH = 16
)
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [DW-1:0]            din,
   output logic [DW-1:0]            dout_c,
   output logic                     full_c,
   output logic                     empty_c,
   output logic [$clog2(DEPTH):0]   count_c
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [DW-1:0] mem [DEPTH];
   logic [PW-1:0] wptr;
   logic [PW-1:0] rptr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push) wptr <= wptr + PW'(1);
         if (pop)  rptr <= rptr + PW'(1);
      end
   end

   // A push into a full queue with a pop lands in the slot being read, after the read.
   always_ff @(posedge clk) begin
      if (push) mem[wptr[AW-1:0]] <= din;
   end

   assign dout_c  = mem[rptr[AW-1:0]];
   assign count_c = wptr - rptr;
   assign empty_c = (wptr == rptr);
   assign full_c  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/oh_simaligner.sv
// Aligns queued expected values with variable-latency DUT results and drives the checker pair.
module oh_simaligner
   import oh_simaligner_pkg::*;
#(
   parameter int unsigned DW      = 32,
   parameter int unsigned DEPTH   = 16,
   parameter int unsigned TIMEOUT = 1024
)
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     ref_valid,
   input  logic [DW-1:0]            ref_data,
   input  logic                     dut_valid,
   input  logic [DW-1:0]            dut_data,
   output logic [DW-1:0]            result,
   output logic [DW-1:0]            reference,
   output logic                     pair_valid,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic                     underflow,
   output logic                     timeout
);

   localparam int unsigned WW = cnt_width(TIMEOUT);
   localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT);

   logic [DW-1:0] head_c;
   logic          full_c;
   logic          empty_c;
   logic          pop_q_c;
   logic          bypass_c;
   logic          unf_c;
   logic          push_c;
   logic          drop_c;
   logic [WW-1:0] wd;

   // Bypass serves an expected value that arrives with its result into an empty queue.
   always_comb begin
      pop_q_c  = dut_valid & ~empty_c;
      bypass_c = dut_valid & empty_c & ref_valid;
      unf_c    = dut_valid & empty_c & ~ref_valid;
      push_c   = ref_valid & ~bypass_c & (~full_c | pop_q_c);
      drop_c   = ref_valid & full_c & ~pop_q_c;
   end

   oh_simaligner_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (push_c),
      .pop     (pop_q_c),
      .din     (ref_data),
      .dout_c  (head_c),
      .full_c  (full_c),
      .empty_c (empty_c),
      .count_c (count)
   );

   // Idle cycles copy reference into result so the checker sees equal values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         result     <= '0;
         reference  <= '0;
         pair_valid <= 1'b0;
         overflow   <= 1'b0;
         underflow  <= 1'b0;
      end else begin
         pair_valid <= pop_q_c | bypass_c;
         if (pop_q_c | bypass_c) begin
            result    <= dut_data;
            reference <= pop_q_c ? head_c : ref_data;
         end else if (unf_c) begin
            result    <= dut_data;
            reference <= ~dut_data;
         end else begin
            result    <= reference;
         end
         if (drop_c) overflow  <= 1'b1;
         if (unf_c)  underflow <= 1'b1;
      end
   end

   // Watchdog saturates at TIMEOUT; with TIMEOUT=0 it never leaves zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wd      <= '0;
         timeout <= 1'b0;
      end else if (pop_q_c || empty_c) begin
         wd <= '0;
      end else if (wd != WD_MAX) begin
         wd <= wd + WW'(1);
         if (wd == WD_MAX - WW'(1)) timeout <= 1'b1;
      end
   end

`ifdef CFG_SIM
   always @(posedge overflow)  $display("ERROR: oh_simaligner overflow at %0t", $time);
   always @(posedge underflow) $display("ERROR: oh_simaligner underflow at %0t", $time);
   always @(posedge timeout)   $display("ERROR: oh_simaligner timeout at %0t", $time);
`endif

endmodule

// File: tb/tb_oh_simaligner.sv
// Scoreboard bench for oh_simaligner against a queue-based reference model.
module tb_oh_simaligner;

   localparam int unsigned DW      = 32;
   localparam int unsigned DEPTH   = 16;
   localparam int unsigned TIMEOUT = 8;

   logic                   clk = 1'b0;
   logic                   reset = 1'b0;
   logic                   ref_valid = 1'b0;
   logic [DW-1:0]          ref_data = '0;
   logic                   dut_valid = 1'b0;
   logic [DW-1:0]          dut_data = '0;
   logic [DW-1:0]          result;
   logic [DW-1:0]          reference;
   logic                   pair_valid;
   logic [$clog2(DEPTH):0] count;
   logic                   overflow;
   logic                   underflow;
   logic                   timeout;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [DW-1:0] res;
      logic [DW-1:0] refv;
   } pair_t;

   pair_t         exp_q[$];
   logic [DW-1:0] mq[$];
   logic [DW-1:0] m_res, m_ref;
   bit            m_ovf, m_unf, m_to;
   int            m_wd;

   always #5 clk = ~clk;

   oh_simaligner #(
      .DW      (DW),
      .DEPTH   (DEPTH),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .ref_valid  (ref_valid),
      .ref_data   (ref_data),
      .dut_valid  (dut_valid),
      .dut_data   (dut_data),
      .result     (result),
      .reference  (reference),
      .pair_valid (pair_valid),
      .count      (count),
      .overflow   (overflow),
      .underflow  (underflow),
      .timeout    (timeout)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every presented pair must match the next scoreboard entry.
   always @(negedge clk) begin : mon
      pair_t e;
      if (!reset && pair_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_pair", 64'(exp_q.size()), 64'd1);
         end else begin
            e = exp_q.pop_front();
            chk("pair_result", result, e.res);
            chk("pair_reference", reference, e.refv);
         end
      end
   end

   task automatic model_clear();
      mq.delete();
      exp_q.delete();
      m_res = '0; m_ref = '0;
      m_ovf = 0; m_unf = 0; m_to = 0;
      m_wd  = 0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      chk("rst_count", count, 0);
      chk("rst_result", result, 0);
      chk("rst_reference", reference, 0);
      chk("rst_pair_valid", pair_valid, 0);
      chk("rst_flags", {overflow, underflow, timeout}, 0);
      model_clear();
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   // One clock of stimulus; the model applies the behavioural rules, then state is compared.
   task automatic step(input bit rv, input logic [DW-1:0] rd, input bit dv, input logic [DW-1:0] dd);
      logic [DW-1:0] popped;
      bit            was_empty;
      bit            did_pop;
      ref_valid = rv; ref_data = rd; dut_valid = dv; dut_data = dd;
      popped    = '0;
      was_empty = (mq.size() == 0);
      did_pop   = 0;
      if (dv && !was_empty) begin
         popped  = mq.pop_front();
         did_pop = 1;
         if (rv) mq.push_back(rd);
      end else if (dv && rv) begin
         popped = rd;
      end else if (rv) begin
         if (mq.size() < DEPTH) mq.push_back(rd);
         else m_ovf = 1;
      end
      if (dv && (!was_empty || rv)) begin
         m_res = dd; m_ref = popped;
         exp_q.push_back('{dd, popped});
      end else if (dv) begin
         m_unf = 1; m_res = dd; m_ref = ~dd;
      end else begin
         m_res = m_ref;
      end
      if (did_pop || was_empty) m_wd = 0;
      else if (m_wd < int'(TIMEOUT)) begin
         m_wd++;
         if (m_wd == int'(TIMEOUT)) m_to = 1;
      end
      @(posedge clk); #1;
      ref_valid = 0; dut_valid = 0;
      chk("count", count, 64'(mq.size()));
      chk("result", result, m_res);
      chk("reference", reference, m_ref);
      chk("overflow", overflow, m_ovf);
      chk("underflow", underflow, m_unf);
      chk("timeout", timeout, m_to);
   endtask

   function automatic logic [DW-1:0] head_or(input logic [DW-1:0] dflt);
      return (mq.size() > 0) ? mq[0] : dflt;
   endfunction

   initial begin
      logic [DW-1:0] d;
      #1;
      do_reset();

      // In-order pops after three pushes
      step(1, 32'h11, 0, 0);
      step(1, 32'h22, 0, 0);
      step(1, 32'h33, 0, 0);
      step(0, 0, 0, 0);
      step(0, 0, 1, 32'h11);
      step(0, 0, 1, 32'h22);
      step(0, 0, 1, 32'h33);
      step(0, 0, 0, 0);

      // Single-cycle mismatch then equal idle values
      step(1, 32'hA5, 0, 0);
      step(0, 0, 1, 32'hA4);
      step(0, 0, 0, 0);
      chk("idle_equal", result, 32'hA5);

      // Fill, overflow, then simultaneous push/pop across pointer wrap
      do_reset();
      for (int i = 0; i < int'(DEPTH); i++) step(1, DW'(i + 1), 0, 0);
      step(1, 32'h99, 0, 0);
      chk("full_count", count, 16);
      for (int i = 0; i < 20; i++) step(1, $urandom, 1, head_or(0));
      while (mq.size() > 0) step(0, 0, 1, head_or(0));
      step(0, 0, 0, 0);

      // Bypass on empty queue
      do_reset();
      step(1, 32'h7, 1, 32'h7);
      chk("bypass_count", count, 0);
      chk("bypass_no_underflow", underflow, 0);
      step(0, 0, 0, 0);

      // Watchdog fires exactly TIMEOUT cycles after the push
      do_reset();
      step(1, 32'h5, 0, 0);
      repeat (TIMEOUT - 1) step(0, 0, 0, 0);
      chk("timeout_early", timeout, 0);
      step(0, 0, 0, 0);
      chk("timeout_fire", timeout, 1);

      // A pop one cycle before expiry keeps the watchdog quiet
      do_reset();
      step(1, 32'h5, 0, 0);
      repeat (TIMEOUT - 2) step(0, 0, 0, 0);
      step(0, 0, 1, 32'h5);
      repeat (12) step(0, 0, 0, 0);
      chk("timeout_avoided", timeout, 0);

      // Random traffic, mostly matching results with occasional mismatches
      do_reset();
      for (int i = 0; i < 400; i++) begin
         bit rv, dv;
         rv = ($urandom_range(0, 99) < 45);
         dv = ($urandom_range(0, 99) < 40);
         d  = $urandom;
         if (dv) begin
            if ($urandom_range(0, 7) == 0) step(rv, d, 1, $urandom);
            else if (mq.size() > 0)        step(rv, d, 1, mq[0]);
            else                           step(rv, d, 1, d);
         end else begin
            step(rv, d, 0, 0);
         end
      end
      while (mq.size() > 0) step(0, 0, 1, head_or(0));

      // Reset with entries queued, then a result with nothing expected
      do_reset();
      for (int i = 0; i < 5; i++) step(1, $urandom, 0, 0);
      chk("pre_reset_count", count, 5);
      do_reset();
      step(0, 0, 1, 32'h1234);
      chk("post_reset_underflow", underflow, 1);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      chk("scoreboard_drained", 64'(exp_q.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
